// File: rtl/best_score_table_ctrl.sv
// Keeps a sorted table of the DEPTH lowest scores in the register file by
// bubble-swap insertion. It also clears the table and shares the read port with the display.
module best_score_table_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BASE  = 1,
    parameter logic [12:0] EMPTY = 13'h1FFF
) (
    input  logic        Clock,
    input  logic        CLRN,
    input  logic        insert_valid,
    input  logic [12:0] insert_score,
    output logic        insert_ready,
    input  logic        clear_req,
    output logic [2:0]  rf_read_addr,
    input  logic [12:0] rf_read_data,
    output logic        rf_write_en,
    output logic [2:0]  rf_write_addr,
    output logic [12:0] rf_write_data,
    input  logic [2:0]  disp_addr,
    output logic [12:0] disp_data,
    output logic        disp_valid,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rank
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [2:0] LAST_IDX  = 3'(DEPTH - 1);
    localparam logic [2:0] BASE_ADDR = 3'(BASE);

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [12:0] carry;
    logic [2:0]  slotAddr;
    logic        takeSlot;
    logic        lastIdx;

    assign slotAddr = BASE_ADDR + idx;
    assign lastIdx  = (idx == LAST_IDX);
    // Strict compare: an equal score passes by, so ties rank after the existing entry.
    assign takeSlot = (state == SCAN) && (carry < rf_read_data);

    assign insert_ready = (state == IDLE) && !clear_req;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    always_comb begin
        rf_read_addr  = (state == SCAN) ? slotAddr : disp_addr;
        rf_write_en   = 1'b0;
        rf_write_addr = slotAddr;
        rf_write_data = carry;
        case (state)
            CLEAR: begin
                rf_write_en   = 1'b1;
                rf_write_data = EMPTY;
            end
            SCAN:    rf_write_en = takeSlot;
            default: rf_write_en = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state      <= IDLE;
            idx        <= '0;
            carry      <= '0;
            rank       <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    disp_data  <= rf_read_data;
                    disp_valid <= 1'b1;
                    if (clear_req) begin
                        idx   <= '0;
                        state <= CLEAR;
                    end else if (insert_valid) begin
                        carry <= insert_score;
                        rank  <= '0;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                CLEAR: begin
                    idx <= lastIdx ? '0 : idx + 3'd1;
                    if (lastIdx) state <= DONE;
                end
                SCAN: begin
                    // The displaced entry becomes the new carry; the final carry falls off the table.
                    if (takeSlot) begin
                        carry <= rf_read_data;
                        if (rank == '0) rank <= idx + 3'd1;
                    end
                    idx <= lastIdx ? '0 : idx + 3'd1;
                    if (lastIdx) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_best_score_table_ctrl.sv
// Bench for best_score_table_ctrl: models the 8x13 register file, scoreboards
// every write against expected writes queued at stimulus time, and runs a vector table.
module tb_best_score_table_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned BASE  = 1;
    localparam logic [12:0] EMPTY = 13'h1FFF;

    logic        Clock;
    logic        CLRN;
    logic        insert_valid;
    logic [12:0] insert_score;
    logic        insert_ready;
    logic        clear_req;
    logic [2:0]  rf_read_addr;
    logic [12:0] rf_read_data;
    logic        rf_write_en;
    logic [2:0]  rf_write_addr;
    logic [12:0] rf_write_data;
    logic [2:0]  disp_addr;
    logic [12:0] disp_data;
    logic        disp_valid;
    logic        busy;
    logic        done;
    logic [2:0]  rank;

    best_score_table_ctrl #(.DEPTH(DEPTH), .BASE(BASE), .EMPTY(EMPTY)) dut (
        .Clock(Clock), .CLRN(CLRN),
        .insert_valid(insert_valid), .insert_score(insert_score), .insert_ready(insert_ready),
        .clear_req(clear_req),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .busy(busy), .done(done), .rank(rank)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [12:0] mem [8];
    assign rf_read_data = mem[rf_read_addr];
    always @(posedge Clock) if (rf_write_en) mem[rf_write_addr] <= rf_write_data;

    typedef struct packed {
        logic [2:0]  addr;
        logic [12:0] data;
    } wr_t;

    wr_t expWr[$];
    wr_t obsWr[$];
    always @(negedge Clock) if (rf_write_en) obsWr.push_back('{rf_write_addr, rf_write_data});

    typedef struct {
        logic        clr;
        logic [12:0] score;
        logic [2:0]  rank;
        logic [12:0] tbl [4];
    } vec_t;

    vec_t        vecs [12];
    logic [12:0] refTbl [4];
    int          nCmp = 0;
    int          nErr = 0;

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setVec(input int i, input logic clr, input logic [12:0] score, input logic [2:0] rk,
                          input logic [12:0] t0, input logic [12:0] t1,
                          input logic [12:0] t2, input logic [12:0] t3);
        vecs[i].clr    = clr;
        vecs[i].score  = score;
        vecs[i].rank   = rk;
        vecs[i].tbl[0] = t0;
        vecs[i].tbl[1] = t1;
        vecs[i].tbl[2] = t2;
        vecs[i].tbl[3] = t3;
    endtask

    task automatic modelClear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            expWr.push_back('{3'(BASE + i), EMPTY});
            refTbl[i] = EMPTY;
        end
    endtask

    task automatic modelInsert(input logic [12:0] score);
        logic [12:0] c;
        logic [12:0] t;
        c = score;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (c < refTbl[i]) begin
                expWr.push_back('{3'(BASE + i), c});
                t = refTbl[i];
                refTbl[i] = c;
                c = t;
            end
        end
    endtask

    task automatic drainWrites(input string tag);
        wr_t e;
        wr_t o;
        check({tag, ".numWrites"}, obsWr.size(), expWr.size());
        while (expWr.size() > 0 && obsWr.size() > 0) begin
            e = expWr.pop_front();
            o = obsWr.pop_front();
            check({tag, ".write"}, int'(o), int'(e));
        end
        expWr.delete();
        obsWr.delete();
    endtask

    // Waits at negedges for done; lat starts at 1 for the accepting edge.
    task automatic waitDone(input string tag);
        int lat;
        lat = 1;
        @(negedge Clock);
        while (!done && lat < 40) begin
            @(negedge Clock);
            lat++;
        end
        check({tag, ".latency"}, lat, int'(DEPTH) + 1);
    endtask

    task automatic doClear(input string tag);
        int n;
        modelClear();
        @(negedge Clock);
        clear_req = 1'b1;
        @(posedge Clock);
        #1 clear_req = 1'b0;
        waitDone(tag);
        n = obsWr.size();
        check({tag, ".consecWrites"}, n, int'(DEPTH));
        @(negedge Clock);
        check({tag, ".busyAfter"}, busy, 0);
        drainWrites(tag);
    endtask

    task automatic doInsert(input string tag, input logic [12:0] score, input logic [2:0] expRank);
        int n;
        modelInsert(score);
        @(negedge Clock);
        insert_score = score;
        insert_valid = 1'b1;
        n = 0;
        while (!insert_ready && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check({tag, ".ready"}, insert_ready, 1);
        @(posedge Clock);
        #1 insert_valid = 1'b0;
        waitDone(tag);
        check({tag, ".rank"}, rank, expRank);
        @(negedge Clock);
        check({tag, ".busyAfter"}, busy, 0);
        drainWrites(tag);
    endtask

    initial begin
        int n;
        setVec(0,  1'b1, 13'd300,  3'd1, 13'd300, EMPTY,   EMPTY,   EMPTY);
        setVec(1,  1'b0, 13'd100,  3'd1, 13'd100, 13'd300, EMPTY,   EMPTY);
        setVec(2,  1'b0, 13'd200,  3'd2, 13'd100, 13'd200, 13'd300, EMPTY);
        setVec(3,  1'b0, 13'd200,  3'd3, 13'd100, 13'd200, 13'd200, 13'd300);
        setVec(4,  1'b1, 13'd400,  3'd1, 13'd400, EMPTY,   EMPTY,   EMPTY);
        setVec(5,  1'b0, 13'd100,  3'd1, 13'd100, 13'd400, EMPTY,   EMPTY);
        setVec(6,  1'b0, 13'd300,  3'd2, 13'd100, 13'd300, 13'd400, EMPTY);
        setVec(7,  1'b0, 13'd200,  3'd2, 13'd100, 13'd200, 13'd300, 13'd400);
        setVec(8,  1'b0, 13'd250,  3'd3, 13'd100, 13'd200, 13'd250, 13'd300);
        setVec(9,  1'b0, 13'd500,  3'd0, 13'd100, 13'd200, 13'd250, 13'd300);
        setVec(10, 1'b0, EMPTY,    3'd0, 13'd100, 13'd200, 13'd250, 13'd300);
        setVec(11, 1'b0, 13'd50,   3'd1, 13'd50,  13'd100, 13'd200, 13'd250);

        for (int i = 0; i < 4; i++) refTbl[i] = '0;
        CLRN = 1'b0;
        insert_valid = 1'b0;
        insert_score = '0;
        clear_req = 1'b0;
        disp_addr = '0;

        // Reset state
        repeat (3) @(negedge Clock);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.rank", rank, 0);
        check("reset.dispValid", disp_valid, 0);
        check("reset.writeEn", rf_write_en, 0);
        check("reset.ready", insert_ready, 1);
        CLRN = 1'b1;
        @(negedge Clock);
        check("reset.dispValidAfter", disp_valid, 1);

        // Clear and the insertion vector table
        doClear("clear0");
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].clr) doClear($sformatf("vec%0d.clear", v));
            doInsert($sformatf("vec%0d", v), vecs[v].score, vecs[v].rank);
            for (int i = 0; i < int'(DEPTH); i++)
                check($sformatf("vec%0d.table%0d", v, i), mem[BASE + i], vecs[v].tbl[i]);
        end

        // Display read path: registered, one cycle behind disp_addr
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge Clock);
            disp_addr = 3'(BASE + i);
            @(negedge Clock);
            check($sformatf("disp%0d.data", i), disp_data, vecs[11].tbl[i]);
            check($sformatf("disp%0d.valid", i), disp_valid, 1);
        end

        // Reset mid-SCAN at idx=1 (no write yet for 150 into 50,100,200,250)
        @(negedge Clock);
        insert_score = 13'd150;
        insert_valid = 1'b1;
        @(posedge Clock);
        #1 insert_valid = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("midscan.busy", busy, 1);
        check("midscan.dispValid", disp_valid, 0);
        CLRN = 1'b0;
        #1;
        check("midreset.writeEn", rf_write_en, 0);
        check("midreset.busy", busy, 0);
        check("midreset.rank", rank, 0);
        check("midreset.done", done, 0);
        @(negedge Clock);
        CLRN = 1'b1;
        check("midreset.noWrites", obsWr.size(), 0);
        obsWr.delete();
        doInsert("afterReset", 13'd150, 3'd3);
        check("afterReset.table2", mem[BASE + 2], 13'd150);
        check("afterReset.table3", mem[BASE + 3], 13'd200);

        // clear_req and insert_valid together: clear first, insert right after IDLE returns
        @(negedge Clock);
        clear_req = 1'b1;
        insert_valid = 1'b1;
        insert_score = 13'd600;
        #1;
        check("both.readyLow", insert_ready, 0);
        modelClear();
        modelInsert(13'd600);
        @(posedge Clock);
        #1 clear_req = 1'b0;
        n = 1;
        while (!insert_ready && n < 20) begin
            @(posedge Clock);
            #1 n++;
        end
        check("both.acceptDelay", n, int'(DEPTH) + 2);
        @(posedge Clock);
        #1 insert_valid = 1'b0;
        waitDone("both.insert");
        check("both.rank", rank, 1);
        drainWrites("both");
        check("both.table0", mem[BASE], 13'd600);
        check("both.table1", mem[BASE + 1], EMPTY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
